// File: rtl/avalon_arb_pkg.sv
// Shared types and widths for the
// read/write Avalon-MM arbiter.
package avalon_arb_pkg;

  localparam int BCW   = 6;
  localparam int PENDW = 7;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  // A zero burstcount is illegal; treat it as one beat.
  function automatic logic [BCW-1:0] bc_fix(
    input logic [BCW-1:0] bc
  );
    return (bc == '0) ? BCW'(1) : bc;
  endfunction

endpackage

// File: rtl/avalon_rd_pend_ctr.sv
// Outstanding read-beat counter with
// room check against the return capacity.
module avalon_rd_pend_ctr
  import avalon_arb_pkg::*;
#(
  parameter int MAX_PEND = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BCW-1:0]   add,
  input  logic             add_en,
  input  logic             dec,
  output logic [PENDW-1:0] count,
  output logic             room
);

  logic [PENDW:0] sum;

  assign sum = {1'b0, count}
             + {{(PENDW+1-BCW){1'b0}}, bc_fix(add)};

  assign room = (sum <= (PENDW+1)'(MAX_PEND));

  // Add accepted bursts, retire returned beats, floor at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (add_en) begin
      if (dec) begin
        count <= PENDW'(sum - (PENDW+1)'(1));
      end else begin
        count <= PENDW'(sum);
      end
    end else if (dec && count != '0) begin
      count <= count - PENDW'(1);
    end
  end

  // Flag a returned beat with nothing outstanding
  always_ff @(posedge clk) begin
    if (reset_n && dec && !add_en) begin
      assert (count != '0);
    end
  end

endmodule

// File: rtl/avalon_rw_arbiter.sv
// Round-robin, burst-aware merge of the
// write and read masters onto one port.
module avalon_rw_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int AW       = 17,
  parameter int DW       = 16,
  parameter int MAX_PEND = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [AW-1:0]  wr_address,
  input  logic           wr_write,
  input  logic [DW-1:0]  wr_writedata,
  input  logic [BCW-1:0] wr_burstcount,
  output logic           wr_waitrequest,
  input  logic [AW-1:0]  rd_address,
  input  logic           rd_read,
  input  logic [BCW-1:0] rd_burstcount,
  output logic           rd_waitrequest,
  output logic           rd_readdatavalid,
  output logic [DW-1:0]  rd_readdata,
  output logic [AW-1:0]  avm_address,
  output logic           avm_write,
  output logic           avm_read,
  output logic [DW-1:0]  avm_writedata,
  output logic [BCW-1:0] avm_burstcount,
  input  logic           avm_waitrequest,
  input  logic           avm_readdatavalid,
  input  logic [DW-1:0]  avm_readdata
);

  state_t           state, state_nx;
  logic [BCW-1:0]   beats, beats_nx;
  logic             last_wr, last_wr_nx;
  logic             wr_begun, wr_begun_nx;
  logic [PENDW-1:0] pend;
  logic             room;
  logic             rd_elig;
  logic             rd_acc;
  logic             wr_acc;

  assign rd_readdatavalid = avm_readdatavalid;
  assign rd_readdata      = avm_readdata;

  avalon_rd_pend_ctr #(
    .MAX_PEND (MAX_PEND)
  ) u_pend (
    .clk     (clk),
    .reset_n (reset_n),
    .add     (rd_burstcount),
    .add_en  (rd_acc),
    .dec     (avm_readdatavalid),
    .count   (pend),
    .room    (room)
  );

  // Arbiter state, remaining write beats and fairness flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      beats    <= '0;
      last_wr  <= 1'b1;
      wr_begun <= 1'b0;
    end else begin
      state    <= state_nx;
      beats    <= beats_nx;
      last_wr  <= last_wr_nx;
      wr_begun <= wr_begun_nx;
    end
  end

  // Grant decision, burst tracking and port muxing
  always_comb begin
    state_nx       = state;
    beats_nx       = beats;
    last_wr_nx     = last_wr;
    wr_begun_nx    = wr_begun;
    avm_write      = 1'b0;
    avm_read       = 1'b0;
    wr_waitrequest = 1'b1;
    rd_waitrequest = 1'b1;
    avm_address    = wr_address;
    avm_burstcount = wr_burstcount;
    avm_writedata  = wr_writedata;
    rd_elig        = rd_read & room;
    rd_acc         = 1'b0;
    wr_acc         = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          (rd_elig && (!wr_write || last_wr)): begin
            state_nx   = RD;
            last_wr_nx = 1'b0;
          end
          (wr_write && (!rd_elig || !last_wr)): begin
            state_nx    = WR;
            last_wr_nx  = 1'b1;
            beats_nx    = bc_fix(wr_burstcount);
            wr_begun_nx = 1'b0;
          end
          default: ;
        endcase
      end
      WR: begin
        avm_write      = wr_write;
        wr_waitrequest = avm_waitrequest;
        wr_acc         = wr_write & ~avm_waitrequest;
        if (wr_acc) begin
          beats_nx    = beats - BCW'(1);
          wr_begun_nx = 1'b1;
          if (beats == BCW'(1)) begin
            state_nx = IDLE;
          end
        end else if (!wr_write && !wr_begun) begin
          state_nx = IDLE;
        end
      end
      RD: begin
        avm_read       = rd_read;
        rd_waitrequest = avm_waitrequest;
        avm_address    = rd_address;
        avm_burstcount = rd_burstcount;
        rd_acc         = rd_read & ~avm_waitrequest;
        if (!rd_read || rd_acc) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_rw_arbiter.sv
// Bench for avalon_rw_arbiter: directed
// scenarios plus random traffic vs a model.
module tb_avalon_rw_arbiter;
  import avalon_arb_pkg::*;

  localparam int AW       = 17;
  localparam int DW       = 16;
  localparam int MAX_PEND = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [AW-1:0]  wr_address;
  logic           wr_write;
  logic [DW-1:0]  wr_writedata;
  logic [BCW-1:0] wr_burstcount;
  logic           wr_waitrequest;
  logic [AW-1:0]  rd_address;
  logic           rd_read;
  logic [BCW-1:0] rd_burstcount;
  logic           rd_waitrequest;
  logic           rd_readdatavalid;
  logic [DW-1:0]  rd_readdata;
  logic [AW-1:0]  avm_address;
  logic           avm_write;
  logic           avm_read;
  logic [DW-1:0]  avm_writedata;
  logic [BCW-1:0] avm_burstcount;
  logic           avm_waitrequest;
  logic           avm_readdatavalid;
  logic [DW-1:0]  avm_readdata;

  always #5 clk = ~clk;

  avalon_rw_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wr_address        (wr_address),
    .wr_write          (wr_write),
    .wr_writedata      (wr_writedata),
    .wr_burstcount     (wr_burstcount),
    .wr_waitrequest    (wr_waitrequest),
    .rd_address        (rd_address),
    .rd_read           (rd_read),
    .rd_burstcount     (rd_burstcount),
    .rd_waitrequest    (rd_waitrequest),
    .rd_readdatavalid  (rd_readdatavalid),
    .rd_readdata       (rd_readdata),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_writedata     (avm_writedata),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_readdata      (avm_readdata)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int b);
    return (b == 0) ? 1 : b;
  endfunction

  // Reference: who owns the port (0 none, 1 writer,
  // 2 reader), beats left in the write burst, whether
  // the writer has moved any beat, who was served
  // last, and read beats still owed by the slave.
  int owner   = 0;
  int w_rem   = 0;
  bit w_moved = 0;
  bit served_wr = 1;
  int owed    = 0;

  bit             wr_acc_s;
  bit             rd_acc_s;
  logic [BCW-1:0] acc_bc;

  task automatic step();
    logic ew, er, rd_ok;
    int n_owner, n_rem, n_owed;
    bit n_moved, n_served;
    #1;
    ew = (owner == 1) && wr_write;
    er = (owner == 2) && rd_read;
    chk("avm_write", avm_write, ew);
    chk("avm_read", avm_read, er);
    chk("wr_wait", wr_waitrequest,
        (owner == 1) ? avm_waitrequest : 1'b1);
    chk("rd_wait", rd_waitrequest,
        (owner == 2) ? avm_waitrequest : 1'b1);
    if (ew) begin
      chk("w_addr", avm_address, wr_address);
      chk("w_data", avm_writedata, wr_writedata);
      chk("w_bc", avm_burstcount, wr_burstcount);
    end
    if (er) begin
      chk("r_addr", avm_address, rd_address);
      chk("r_bc", avm_burstcount, rd_burstcount);
    end
    chk("rdv", rd_readdatavalid, avm_readdatavalid);
    chk("rdata", rd_readdata, avm_readdata);
    chk("pend", dut.u_pend.count, owed);
    wr_acc_s = wr_write && !wr_waitrequest;
    rd_acc_s = rd_read && !rd_waitrequest;
    acc_bc   = avm_burstcount;
    n_owner  = owner;
    n_rem    = w_rem;
    n_moved  = w_moved;
    n_served = served_wr;
    n_owed   = owed;
    if (!reset_n) begin
      n_owner  = 0;
      n_rem    = 0;
      n_moved  = 0;
      n_served = 1;
      n_owed   = 0;
    end else begin
      if (er && !avm_waitrequest)
        n_owed += eff(rd_burstcount);
      if (avm_readdatavalid && n_owed > 0)
        n_owed--;
      if (owner == 0) begin
        rd_ok = rd_read &&
          (owed + eff(rd_burstcount) <= MAX_PEND);
        if (rd_ok && (!wr_write || served_wr)) begin
          n_owner  = 2;
          n_served = 0;
        end else if (wr_write) begin
          n_owner  = 1;
          n_served = 1;
          n_rem    = eff(wr_burstcount);
          n_moved  = 0;
        end
      end else if (owner == 1) begin
        if (ew && !avm_waitrequest) begin
          n_rem--;
          n_moved = 1;
          if (n_rem == 0) n_owner = 0;
        end else if (!wr_write && !w_moved) begin
          n_owner = 0;
        end
      end else begin
        if (!rd_read || !avm_waitrequest)
          n_owner = 0;
      end
    end
    @(posedge clk);
    owner     = n_owner;
    w_rem     = n_rem;
    w_moved   = n_moved;
    served_wr = n_served;
    owed      = n_owed;
    @(negedge clk);
  endtask

  task automatic rd_issue(input int bc);
    bit ok;
    rd_read       = 1'b1;
    rd_burstcount = BCW'(bc);
    rd_address    = AW'($urandom);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = rd_acc_s;
    end
    rd_read = 1'b0;
    chk("rd_issue", ok, 1'b1);
  endtask

  task automatic drain();
    wr_write        = 1'b0;
    rd_read         = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 300 && owed > 0; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = DW'($urandom);
      step();
    end
    avm_readdatavalid = 1'b0;
    chk("drain", dut.u_pend.count, 0);
  endtask

  int w_left  = 0;
  bit w_first = 0;

  task automatic rand_cycle();
    if (w_left == 0) begin
      wr_write = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        wr_burstcount = BCW'($urandom_range(0, 8));
        w_left        = eff(int'(wr_burstcount));
        w_first       = 1;
        wr_address    = AW'($urandom);
        wr_writedata  = DW'($urandom);
        wr_write      = 1'b1;
      end
    end else if (!w_first) begin
      wr_write = ($urandom_range(0, 3) != 0);
    end
    if (!rd_read && $urandom_range(0, 3) == 0) begin
      rd_read       = 1'b1;
      rd_burstcount = BCW'($urandom_range(0, 16));
      rd_address    = AW'($urandom);
    end
    avm_waitrequest   = ($urandom_range(0, 2) == 0);
    avm_readdatavalid = (owed > 0) &&
                        ($urandom_range(0, 1) == 1);
    avm_readdata      = DW'($urandom);
    step();
    if (wr_acc_s) begin
      w_left--;
      w_first      = 0;
      wr_writedata = DW'($urandom);
      if (w_left == 0) wr_write = 1'b0;
    end
    if (rd_acc_s) rd_read = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    int ng, wb, n, early;
    bit ok;
    reset_n           = 1'b0;
    wr_address        = '0;
    wr_write          = 1'b0;
    wr_writedata      = '0;
    wr_burstcount     = '0;
    rd_address        = '0;
    rd_read           = 1'b0;
    rd_burstcount     = '0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", dut.state, IDLE);
    chk("rst_wrw", wr_waitrequest, 1'b1);
    chk("rst_rdw", rd_waitrequest, 1'b1);
    chk("rst_aw", avm_write, 1'b0);
    chk("rst_ar", avm_read, 1'b0);
    chk("rst_pend", dut.u_pend.count, 0);
    reset_n = 1'b1;

    // Both channels busy: RD, WR, RD, WR
    wr_write      = 1'b1;
    wr_burstcount = 6'd2;
    rd_read       = 1'b1;
    rd_burstcount = 6'd2;
    g  = '0;
    ng = 0;
    wb = 0;
    for (int i = 0; i < 40 && (ng < 4 || wb != 0); i++) begin
      avm_readdatavalid = (owed > 0);
      step();
      if (rd_acc_s) begin
        g = {g[2:0], 1'b0};
        ng++;
      end
      if (wr_acc_s) begin
        if (wb == 0) begin
          g = {g[2:0], 1'b1};
          ng++;
        end
        wb = (wb + 1) % 2;
      end
    end
    wr_write = 1'b0;
    rd_read  = 1'b0;
    chk("alt_n", ng, 4);
    chk("alt_seq", g, 4'b0101);
    drain();

    // Write of 4 under toggling waitrequest
    wr_write      = 1'b1;
    wr_burstcount = 6'd4;
    wr_address    = AW'($urandom);
    wr_writedata  = DW'($urandom);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      avm_waitrequest = i[0];
      step();
      if (wr_acc_s) begin
        if (n == 0) chk("wr4_bc", acc_bc, 4);
        n++;
        wr_writedata = DW'($urandom);
      end
    end
    wr_write        = 1'b0;
    avm_waitrequest = 1'b0;
    chk("wr4_beats", n, 4);
    chk("wr4_idle", dut.state, IDLE);

    // Pend limit: 32 + 32 fills it, 8 must wait
    rd_issue(32);
    rd_issue(32);
    rd_read       = 1'b1;
    rd_burstcount = 6'd8;
    early = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (rd_acc_s) early++;
    end
    chk("rd3_stall", rd_waitrequest, 1'b1);
    for (int i = 0; i < 8; i++) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = DW'($urandom);
      step();
      if (rd_acc_s) early++;
    end
    avm_readdatavalid = 1'b0;
    chk("rd3_early", early, 0);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      ok = rd_acc_s;
    end
    rd_read = 1'b0;
    chk("rd3_issue", ok, 1'b1);
    drain();

    // Accept of 4 with a beat returning, pend 5
    rd_issue(5);
    rd_read       = 1'b1;
    rd_burstcount = 6'd4;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      avm_readdatavalid = (owner == 2);
      step();
      ok = rd_acc_s;
    end
    avm_readdatavalid = 1'b0;
    rd_read           = 1'b0;
    chk("coinc_acc", ok, 1'b1);
    chk("coinc_pend", dut.u_pend.count, 8);
    drain();

    // Write of 8 while read data returns
    rd_issue(6);
    wr_write      = 1'b1;
    wr_burstcount = 6'd8;
    n = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      avm_readdatavalid = (owed > 0);
      avm_readdata      = DW'($urandom);
      step();
      if (wr_acc_s) begin
        n++;
        wr_writedata = DW'($urandom);
      end
    end
    wr_write          = 1'b0;
    avm_readdatavalid = 1'b0;
    chk("wr8_beats", n, 8);
    chk("wr8_pend", dut.u_pend.count, 0);

    // Reset in the middle of a write burst
    rd_issue(3);
    wr_write      = 1'b1;
    wr_burstcount = 6'd4;
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      step();
      if (wr_acc_s) n++;
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_aw", avm_write, 1'b0);
    chk("mid_wrw", wr_waitrequest, 1'b1);
    chk("mid_rdw", rd_waitrequest, 1'b1);
    chk("mid_pend", dut.u_pend.count, 0);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      step();
      if (wr_acc_s) n++;
    end
    wr_write = 1'b0;
    chk("mid_next", n, 4);

    // Write withdrawn before any beat moves
    wr_write        = 1'b1;
    wr_burstcount   = 6'd3;
    avm_waitrequest = 1'b1;
    repeat (3) step();
    wr_write = 1'b0;
    repeat (2) step();
    avm_waitrequest = 1'b0;
    chk("wd_idle", dut.state, IDLE);

    // Random traffic
    drain();
    repeat (3000) rand_cycle();

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
